// File: rtl/uart_txrx.sv
// 8N1 UART transmitter and receiver running independently off one clock.
// Define UART_RX_SYNC_EN to put rx through a two-flop synchronizer (+2 cycles RX latency).
module uart_txrx #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_done,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

  // ---------------------------------------------------------------- TX path
  state_e           tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_q, tx_d;
  logic             tx_done_q, tx_done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // Line level is registered from the next state so tx changes with the state.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_done_d  = 1'b0;
    tx_d       = 1'b1;
    unique case (tx_state_q)
      ST_IDLE: begin
        if (tx_start) begin
          tx_shift_d = tx_data;
          tx_cnt_d   = '0;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = ST_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_done_d  = 1'b1;
          tx_state_d = ST_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
    unique case (tx_state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = tx_shift_d[tx_bit_d];
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx      = tx_q;
  assign tx_done = tx_done_q;

  // ---------------------------------------------------------------- RX path
  logic rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] rx_sync_q;

  always_ff @(posedge clk) begin
    if (reset) rx_sync_q <= 2'b11;
    else       rx_sync_q <= {rx_sync_q[0], rx};
  end

  assign rx_s = rx_sync_q[1];
`else
  assign rx_s = rx;
`endif

  state_e           rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_ferr_q, rx_ferr_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_done_q, rx_done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_ferr_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_done_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_data_q  <= rx_data_d;
      rx_done_q  <= rx_done_d;
    end
  end

  // After a framing error, STOP holds until the line returns high.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_ferr_d  = rx_ferr_q;
    rx_data_d  = rx_data_q;
    rx_done_d  = 1'b0;
    unique case (rx_state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (rx_ferr_q) begin
          if (rx_s) begin
            rx_ferr_d  = 1'b0;
            rx_state_d = ST_IDLE;
          end
        end else if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rx_s) begin
            rx_data_d  = rx_shift_q;
            rx_done_d  = 1'b1;
            rx_state_d = ST_IDLE;
          end else begin
            rx_ferr_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  assign rx_data = rx_data_q;
  assign rx_done = rx_done_q;

endmodule

// File: tb/tb_uart_txrx.sv
// Scoreboard bench for uart_txrx: loopback and bit-banged RX frames, glitch,
// framing error, back-to-back, ignored tx_start and mid-frame reset.
module tb_uart_txrx;

  localparam int unsigned CLK_FREQ  = 1600000;
  localparam int unsigned BAUD_RATE = 100000;
  localparam int unsigned CPB       = CLK_FREQ / BAUD_RATE;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx;
  logic       tx_done;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       loop_en;
  logic       rx_drv;

  int n_checks = 0;
  int n_fail   = 0;
  int tx_done_cnt = 0;
  int rx_done_cnt = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  assign rx_line = loop_en ? tx : rx_drv;

  uart_txrx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx       (tx),
    .tx_done  (tx_done),
    .rx       (rx_line),
    .rx_data  (rx_data),
    .rx_done  (rx_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Output monitor: counts done pulses and pops the scoreboard on rx_done.
  always @(negedge clk) begin
    if (tx_done) tx_done_cnt++;
    if (rx_done) begin
      rx_done_cnt++;
      if (sb_q.size() == 0) check("rx_unexpected_sb_size", 32'(sb_q.size()), 32'd1);
      else                  check("rx_data", 32'(rx_data), 32'(sb_q.pop_front()));
    end
  end

  task automatic start_tx(input logic [7:0] d, input bit push);
    tx_data  = d;
    tx_start = 1'b1;
    if (push) sb_q.push_back(d);
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    tx_data  = ~d;
  endtask

  task automatic wait_tx_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (tx_done) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic send_rx_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    if (stop) sb_q.push_back(d);
    for (int k = 0; k < 10; k++) begin
      rx_drv = f[k];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx0, rx0;
    logic [9:0] frame;
    reset    = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    loop_en  = 1'b1;
    rx_drv   = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("reset_tx",      32'(tx),      32'd1);
    check("reset_tx_done", 32'(tx_done), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_done", 32'(rx_done), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // A5 loopback with bit-by-bit line check at each bit centre
    tx0 = tx_done_cnt; rx0 = rx_done_cnt;
    frame = {1'b1, 8'hA5, 1'b0};
    start_tx(8'hA5, 1'b1);
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? CPB / 2 : CPB) @(negedge clk);
      check($sformatf("tx_bit%0d", k), 32'(tx), 32'(frame[k]));
    end
    wait_tx_done("a5_tx_done");
    repeat (30) @(negedge clk);
    check("a5_tx_done_cnt", 32'(tx_done_cnt - tx0), 32'd1);
    check("a5_rx_done_cnt", 32'(rx_done_cnt - rx0), 32'd1);
    check("a5_rx_data",     32'(rx_data),           32'hA5);

    // Back-to-back 00 then FF, next start on the tx_done cycle
    tx0 = tx_done_cnt; rx0 = rx_done_cnt;
    start_tx(8'h00, 1'b1);
    wait_tx_done("b2b_first_done");
    start_tx(8'hFF, 1'b1);
    @(negedge clk);
    check("b2b_no_gap", 32'(tx), 32'd0);
    wait_tx_done("b2b_second_done");
    repeat (30) @(negedge clk);
    check("b2b_tx_done_cnt", 32'(tx_done_cnt - tx0), 32'd2);
    check("b2b_rx_done_cnt", 32'(rx_done_cnt - rx0), 32'd2);
    check("b2b_rx_data",     32'(rx_data),           32'hFF);

    // tx_start mid-frame is ignored
    tx0 = tx_done_cnt; rx0 = rx_done_cnt;
    start_tx(8'h5A, 1'b1);
    repeat (50) @(negedge clk);
    start_tx(8'h3C, 1'b0);
    wait_tx_done("ign_tx_done");
    repeat (200) @(negedge clk);
    check("ign_tx_done_cnt", 32'(tx_done_cnt - tx0), 32'd1);
    check("ign_rx_done_cnt", 32'(rx_done_cnt - rx0), 32'd1);
    check("ign_rx_data",     32'(rx_data),           32'h5A);

    // Short low glitch rejected, then a valid 81 frame
    loop_en = 1'b0;
    rx0 = rx_done_cnt;
    @(posedge clk);
    #1;
    rx_drv = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    #1;
    rx_drv = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_no_done", 32'(rx_done_cnt - rx0), 32'd0);
    send_rx_frame(8'h81, 1'b1);
    repeat (20) @(negedge clk);
    check("glitch_next_cnt",  32'(rx_done_cnt - rx0), 32'd1);
    check("glitch_next_data", 32'(rx_data),           32'h81);

    // Framing error: 55 with stop bit 0 discarded, then C3 accepted
    rx0 = rx_done_cnt;
    send_rx_frame(8'h55, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("ferr_no_done",   32'(rx_done_cnt - rx0), 32'd0);
    check("ferr_data_held", 32'(rx_data),           32'h81);
    send_rx_frame(8'hC3, 1'b1);
    repeat (20) @(negedge clk);
    check("ferr_next_cnt",  32'(rx_done_cnt - rx0), 32'd1);
    check("ferr_next_data", 32'(rx_data),           32'hC3);

    // Reset during DATA of both paths
    loop_en = 1'b1;
    @(posedge clk);
    #1;
    tx0 = tx_done_cnt; rx0 = rx_done_cnt;
    start_tx(8'hA5, 1'b0);
    repeat (60) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_tx",      32'(tx),      32'd1);
    check("midrst_tx_done", 32'(tx_done), 32'd0);
    check("midrst_rx_done", 32'(rx_done), 32'd0);
    check("midrst_rx_data", 32'(rx_data), 32'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (200) @(negedge clk);
    check("midrst_no_tx_done", 32'(tx_done_cnt - tx0), 32'd0);
    check("midrst_no_rx_done", 32'(rx_done_cnt - rx0), 32'd0);
    check("midrst_line_idle",  32'(tx),                 32'd1);
    start_tx(8'hA5, 1'b1);
    wait_tx_done("post_rst_tx_done");
    repeat (30) @(negedge clk);
    check("post_rst_rx_cnt",  32'(rx_done_cnt - rx0), 32'd1);
    check("post_rst_rx_data", 32'(rx_data),           32'hA5);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
